game_level_controller: RTL and testbench

- Parametrised game-flow controller for the VGA obstacle game: N levels, a lives counter, multi-obstacle collision detection and timed pause states.
- Sits between the ball/obstacle motion blocks and the colour mapper.
- Consumes sprite positions once per frame.
- Drives level, obstacle speed, active obstacle count, palette select and player/obstacle reset pulses.

---
 rtl/game_level_controller.sv | 218 +++++++++++++++++++++
 tb/tb_game_level_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_level_controller.sv
// ---------------------------------------------------------------------------
// game_level_controller
//   Game-flow controller for the VGA obstacle game. Tracks level and lives,
//   tests the ball against the active obstacles once per frame, and times the
//   HIT / LEVEL_UP pauses. Drives speed, obstacle count, palette and the
//   player/obstacle reset pulses for the motion blocks and colour mapper.
//
// Ports
//   clk                 : system clock
//   reset               : asynchronous, active-low reset
//   frame_tick          : one-cycle pulse per frame; game decisions use it
//   start               : start / restart request
//   ball_x/y, ball_size : ball centre and half-size
//   obs_x/y             : packed obstacle centres, obstacle i at [i*COORD_W +: COORD_W]
//   obs_size            : common obstacle half-size
//   finish_line_reached : ball is at the goal
//   state_o             : IDLE=0 PLAY=1 HIT=2 LEVEL_UP=3 GAME_OVER=4 WIN=5
//   level, lives        : current level (0-based) and remaining lives
//   speed               : level+1 in PLAY, else 0
//   obstacle_count      : min(level+1, NUM_OBS) in PLAY/HIT/LEVEL_UP, else 0
//   palette             : IDLE 0, PLAY/HIT/LEVEL_UP level+1, GAME_OVER 8, WIN 9
//   collision           : one-cycle pulse after a counted hit
//   reset_player        : one-cycle pulse
//   reset_obstacles     : one-cycle pulse
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | waiting for start
// PLAY      | game running, hit/finish evaluated on frame_tick
// HIT       | pause after losing a life
// LEVEL_UP  | pause after reaching the finish line
// GAME_OVER | no lives left, wait for start on a frame_tick
// WIN       | last level finished, wait for start on a frame_tick
// ---------------------------------------------------------------------------
module game_level_controller #(
  parameter int NUM_LEVELS   = 3,
  parameter int NUM_OBS      = 4,
  parameter int COORD_W      = 10,
  parameter int LIVES        = 3,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
  input  logic                       start,
  input  logic [COORD_W-1:0]         ball_x,
  input  logic [COORD_W-1:0]         ball_y,
  input  logic [COORD_W-1:0]         ball_size,
  input  logic [NUM_OBS*COORD_W-1:0] obs_x,
  input  logic [NUM_OBS*COORD_W-1:0] obs_y,
  input  logic [COORD_W-1:0]         obs_size,
  input  logic                       finish_line_reached,
  output logic [2:0]                 state_o,
  output logic [2:0]                 level,
  output logic [3:0]                 lives,
  output logic [3:0]                 speed,
  output logic [3:0]                 obstacle_count,
  output logic [3:0]                 palette,
  output logic                       collision,
  output logic                       reset_player,
  output logic                       reset_obstacles
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PLAY      = 3'd1;
  localparam logic [2:0] S_HIT       = 3'd2;
  localparam logic [2:0] S_LEVEL_UP  = 3'd3;
  localparam logic [2:0] S_GAME_OVER = 3'd4;
  localparam logic [2:0] S_WIN       = 3'd5;

  localparam int CW = COORD_W + 2;
  localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

  localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_FRAMES - 1);
  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
  localparam logic [2:0]    LAST_LVL   = 3'(NUM_LEVELS - 1);
  localparam logic [3:0]    OBS_MAX    = 4'(NUM_OBS);

  logic [2:0]    state_q, state_d;
  logic [2:0]    level_q, level_d;
  logic [3:0]    lives_q, lives_d;
  logic [PW-1:0] pause_q, pause_d;
  logic          collision_q, collision_d;
  logic          rst_player_q, rst_player_d;
  logic          rst_obs_q, rst_obs_d;

  logic [3:0]       level_p1;
  logic [3:0]       active_obs;
  logic [NUM_OBS-1:0] obs_hit;
  logic             hit_any;
  logic [CW-1:0]    bx, by, sz_sum;

  assign level_p1   = {1'b0, level_q} + 4'd1;
  assign active_obs = (level_p1 > OBS_MAX) ? OBS_MAX : level_p1;

  // Widened by two bits so centre + two half-sizes can never wrap.
  assign bx     = CW'(ball_x);
  assign by     = CW'(ball_y);
  assign sz_sum = CW'(ball_size) + CW'(obs_size);

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    logic [CW-1:0] ox, oy;
    logic          x_ov, y_ov;
    assign ox   = CW'(obs_x[g*COORD_W +: COORD_W]);
    assign oy   = CW'(obs_y[g*COORD_W +: COORD_W]);
    // Strict inequality: touching edges do not count as a hit.
    assign x_ov = (bx + sz_sum > ox) && (ox + sz_sum > bx);
    assign y_ov = (by + sz_sum > oy) && (oy + sz_sum > by);
    assign obs_hit[g] = x_ov && y_ov && (4'(g) < active_obs);
  end

  assign hit_any = |obs_hit;

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    lives_d      = lives_q;
    pause_d      = pause_q;
    collision_d  = 1'b0;
    rst_player_d = 1'b0;
    rst_obs_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Start is honoured on any cycle, not just on a frame tick.
        if (start) begin
          state_d      = S_PLAY;
          level_d      = 3'd0;
          lives_d      = LIVES_INIT;
          rst_player_d = 1'b1;
          rst_obs_d    = 1'b1;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (hit_any) begin
            lives_d     = lives_q - 4'd1;
            collision_d = 1'b1;
            if (lives_q == 4'd1) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d      = S_HIT;
              pause_d      = PAUSE_LOAD;
              rst_player_d = 1'b1;
            end
          end else if (finish_line_reached) begin
            if (level_q == LAST_LVL) begin
              state_d = S_WIN;
            end else begin
              level_d      = level_q + 3'd1;
              state_d      = S_LEVEL_UP;
              pause_d      = PAUSE_LOAD;
              rst_player_d = 1'b1;
              rst_obs_d    = 1'b1;
            end
          end
        end
      end
      S_HIT, S_LEVEL_UP: begin
        if (frame_tick) begin
          if (pause_q == '0) state_d = S_PLAY;
          else               pause_d = pause_q - PW'(1);
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (frame_tick && start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      level_q      <= 3'd0;
      lives_q      <= LIVES_INIT;
      pause_q      <= '0;
      collision_q  <= 1'b0;
      rst_player_q <= 1'b0;
      rst_obs_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      pause_q      <= pause_d;
      collision_q  <= collision_d;
      rst_player_q <= rst_player_d;
      rst_obs_q    <= rst_obs_d;
    end
  end

  always_comb begin
    speed          = 4'd0;
    obstacle_count = 4'd0;
    palette        = 4'd0;
    case (state_q)
      S_PLAY: begin
        speed          = level_p1;
        obstacle_count = active_obs;
        palette        = level_p1;
      end
      S_HIT, S_LEVEL_UP: begin
        obstacle_count = active_obs;
        palette        = level_p1;
      end
      S_GAME_OVER: palette = 4'd8;
      S_WIN:       palette = 4'd9;
      default: ;
    endcase
  end

  assign state_o         = state_q;
  assign level           = level_q;
  assign lives           = lives_q;
  assign collision       = collision_q;
  assign reset_player    = rst_player_q;
  assign reset_obstacles = rst_obs_q;

endmodule

// File: tb/tb_game_level_controller.sv
module tb_game_level_controller;

  localparam int NL = 3;
  localparam int NO = 4;
  localparam int CWD = 10;
  localparam int LV = 3;
  localparam int PF = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  logic start = 1'b0;
  logic fin = 1'b0;
  logic [CWD-1:0] ball_x = 10'd100;
  logic [CWD-1:0] ball_y = 10'd100;
  logic [CWD-1:0] ball_size = 10'd8;
  logic [CWD-1:0] obs_size = 10'd8;
  logic [NO*CWD-1:0] obs_x;
  logic [NO*CWD-1:0] obs_y;

  logic [2:0] state_o, level;
  logic [3:0] lives, speed, obstacle_count, palette;
  logic collision, reset_player, reset_obstacles;

  int passed = 0;
  int total = 0;
  bit chk_en = 1'b0;

  game_level_controller #(
    .NUM_LEVELS(NL), .NUM_OBS(NO), .COORD_W(CWD), .LIVES(LV), .PAUSE_FRAMES(PF)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .ball_x(ball_x), .ball_y(ball_y), .ball_size(ball_size),
    .obs_x(obs_x), .obs_y(obs_y), .obs_size(obs_size),
    .finish_line_reached(fin),
    .state_o(state_o), .level(level), .lives(lives), .speed(speed),
    .obstacle_count(obstacle_count), .palette(palette), .collision(collision),
    .reset_player(reset_player), .reset_obstacles(reset_obstacles)
  );

  always #5 clk = ~clk;

  // Game model: phase names as plain integers, outputs derived from the rules.
  int m_phase = 0;   // 0 idle,1 play,2 hit,3 level_up,4 game_over,5 win
  int m_level = 0;
  int m_lives = LV;
  int m_wait  = 0;   // frames still to sit in a pause before resuming
  bit e_col = 0, e_rp = 0, e_ro = 0;

  function automatic bit model_hit();
    int active, bx, by, bs, os, ox, oy;
    bit any;
    any = 0;
    active = (m_level + 1 < NO) ? m_level + 1 : NO;
    bx = int'(ball_x); by = int'(ball_y);
    bs = int'(ball_size); os = int'(obs_size);
    for (int i = 0; i < active; i++) begin
      ox = int'(obs_x[i*CWD +: CWD]);
      oy = int'(obs_y[i*CWD +: CWD]);
      if ((bx + bs + os > ox) && (ox + bs + os > bx) &&
          (by + bs + os > oy) && (oy + bs + os > by)) any = 1;
    end
    return any;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_level = 0; m_lives = LV; m_wait = 0;
      e_col = 0; e_rp = 0; e_ro = 0;
    end else begin
      e_col = 0; e_rp = 0; e_ro = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_level = 0; m_lives = LV; e_rp = 1; e_ro = 1;
        end
      end else if (frame_tick) begin
        if (m_phase == 1) begin
          if (model_hit()) begin
            m_lives = m_lives - 1;
            e_col = 1;
            if (m_lives == 0) m_phase = 4;
            else begin m_phase = 2; m_wait = PF - 1; e_rp = 1; end
          end else if (fin) begin
            if (m_level == NL - 1) m_phase = 5;
            else begin
              m_level = m_level + 1; m_phase = 3; m_wait = PF - 1;
              e_rp = 1; e_ro = 1;
            end
          end
        end else if (m_phase == 2 || m_phase == 3) begin
          if (m_wait == 0) m_phase = 1;
          else m_wait = m_wait - 1;
        end else if (start) begin
          m_phase = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    int e_speed, e_cnt, e_pal;
    logic [31:0] act_v, exp_v;
    if (chk_en) begin
      e_speed = (m_phase == 1) ? m_level + 1 : 0;
      e_cnt = (m_phase >= 1 && m_phase <= 3) ? ((m_level + 1 < NO) ? m_level + 1 : NO) : 0;
      e_pal = (m_phase == 0) ? 0 : (m_phase <= 3) ? m_level + 1 : (m_phase == 4) ? 8 : 9;
      act_v = {state_o, level, lives, speed, obstacle_count, palette,
               collision, reset_player, reset_obstacles};
      exp_v = {3'(m_phase), 3'(m_level), 4'(m_lives), 4'(e_speed), 4'(e_cnt), 4'(e_pal),
               e_col, e_rp, e_ro};
      total++;
      if (act_v === exp_v) passed++;
      else $display("FAIL model_cycle t=%0t: dut=%h model=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc(input bit ft, input bit st);
    @(posedge clk); #1;
    frame_tick = ft; start = st;
    @(posedge clk); #1;
    frame_tick = 0; start = 0;
  endtask

  task automatic set_obs(input int i, input int x, input int y);
    obs_x[i*CWD +: CWD] = CWD'(x);
    obs_y[i*CWD +: CWD] = CWD'(y);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1 reset = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NO; i++) set_obs(i, 600, 600);
    #1 reset = 0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("por_state", state_o, 0);
    chk("por_lives", lives, 3);

    // start, then a hit, then reset in the middle of the pause
    cyc(0, 1);
    @(negedge clk); chk("pre_state", state_o, 1);
    set_obs(0, 112, 100);
    cyc(1, 0);
    @(negedge clk); chk("pre_hit_state", state_o, 2);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_lives", lives, 3);
    chk("rst_palette", palette, 0);
    chk("rst_rp", reset_player, 0);
    @(posedge clk); #1 reset = 1;
    set_obs(0, 600, 600);

    // 1: start
    cyc(0, 1);
    @(negedge clk);
    chk("t1_state", state_o, 1);
    chk("t1_level", level, 0);
    chk("t1_speed", speed, 1);
    chk("t1_count", obstacle_count, 1);
    chk("t1_palette", palette, 1);
    chk("t1_rp", reset_player, 1);
    @(negedge clk); chk("t1_rp_drop", reset_player, 0);

    // 2: overlapping hit, pause, touching edges
    set_obs(0, 112, 100);
    cyc(1, 0);
    @(negedge clk);
    chk("t2_col", collision, 1);
    chk("t2_lives", lives, 2);
    chk("t2_state", state_o, 2);
    @(negedge clk); chk("t2_col_drop", collision, 0);
    set_obs(0, 600, 600);
    cyc(1, 0);
    @(negedge clk); chk("t2_pause1", state_o, 2);
    cyc(1, 0);
    @(negedge clk); chk("t2_resume", state_o, 1);
    set_obs(0, 116, 100);
    cyc(1, 0);
    @(negedge clk);
    chk("t2_touch_state", state_o, 1);
    chk("t2_touch_lives", lives, 2);

    // 3: obs1 inactive at level 0, active after level up
    set_obs(0, 600, 600);
    set_obs(1, 112, 100);
    cyc(1, 0);
    @(negedge clk);
    chk("t3_ign_state", state_o, 1);
    chk("t3_ign_lives", lives, 2);
    fin = 1;
    cyc(1, 0);
    fin = 0;
    @(negedge clk);
    chk("t3_lu_state", state_o, 3);
    chk("t3_lu_level", level, 1);
    chk("t3_lu_pal", palette, 2);
    chk("t3_lu_ro", reset_obstacles, 1);
    cyc(1, 0); cyc(1, 0);
    @(negedge clk);
    chk("t3_play", state_o, 1);
    chk("t3_count", obstacle_count, 2);
    chk("t3_speed", speed, 2);

    // 4: finish and hit together, hit wins
    fin = 1;
    cyc(1, 0);
    fin = 0;
    @(negedge clk);
    chk("t4_state", state_o, 2);
    chk("t4_lives", lives, 1);
    chk("t4_level", level, 1);
    chk("t4_col", collision, 1);

    // 5: three finishes to WIN
    pulse_reset();
    set_obs(1, 600, 600);
    cyc(0, 1);
    @(negedge clk); chk("t5_pal0", palette, 1);
    fin = 1;
    cyc(1, 0);
    @(negedge clk); chk("t5_pal1", palette, 2);
    cyc(1, 0); cyc(1, 0);
    cyc(1, 0);
    @(negedge clk);
    chk("t5_pal2", palette, 3);
    chk("t5_level2", level, 2);
    cyc(1, 0); cyc(1, 0);
    cyc(1, 0);
    fin = 0;
    @(negedge clk);
    chk("t5_win", state_o, 5);
    chk("t5_win_pal", palette, 9);
    chk("t5_win_speed", speed, 0);
    cyc(1, 0);
    @(negedge clk); chk("t5_hold", state_o, 5);
    cyc(1, 1);
    @(negedge clk); chk("t5_idle", state_o, 0);
    cyc(0, 1);
    @(negedge clk);
    chk("t5_restart", state_o, 1);
    chk("t5_restart_lvl", level, 0);

    // 6: three hits to GAME_OVER
    set_obs(0, 112, 100);
    cyc(1, 0);
    @(negedge clk); chk("t6_h1", lives, 2);
    cyc(1, 0); cyc(1, 0);
    cyc(1, 0);
    @(negedge clk); chk("t6_h2", lives, 1);
    cyc(1, 0); cyc(1, 0);
    cyc(1, 0);
    @(negedge clk);
    chk("t6_go_state", state_o, 4);
    chk("t6_go_lives", lives, 0);
    chk("t6_go_pal", palette, 8);
    chk("t6_go_rp", reset_player, 0);
    cyc(1, 0);
    @(negedge clk); chk("t6_hold", state_o, 4);
    cyc(1, 1);
    @(negedge clk); chk("t6_idle", state_o, 0);
    set_obs(0, 600, 600);
    cyc(0, 1);
    @(negedge clk);
    chk("t6_restart", state_o, 1);
    chk("t6_lives", lives, 3);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
